fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with 2-entry buffer, redirect and end-of-memory halt
module fetch_unit #(
  parameter int unsigned MEM_DEPTH = 30,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        halted
);

  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_inflight;

  // Buffer slot 0 is always the head; slot 1 only holds data when count == 2.
  logic [1:0]  r_count;
  logic [31:0] r_instr0;
  logic [31:0] r_instr1;
  logic [31:0] r_pcq0;
  logic [31:0] r_pcq1;

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic        w_in_range;
  logic [2:0]  w_occupancy;
  logic [31:0] w_word_idx;
  logic [1:0]  w_unused_redirect_lsb;

  // The low two bits of a redirect target are discarded; word alignment is forced.
  assign w_unused_redirect_lsb = redirect_pc[1:0];

  assign w_word_idx  = {2'b00, r_pc[31:2]};
  assign imem_addr   = w_word_idx;
  assign w_in_range  = (w_word_idx < DEPTH_W);
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};

  assign if_valid = (r_count != 2'd0);
  assign if_instr = if_valid ? r_instr0 : 32'h0;
  assign if_pc    = if_valid ? r_pcq0   : 32'h0;
  assign halted   = (r_state == S_HALT) && (r_count == 2'd0) && !r_inflight;

  assign w_pop  = if_valid && id_ready;
  assign w_push = r_inflight && !redirect_valid;

  // A new request may go out only when its returning word is guaranteed a buffer slot.
  assign w_issue = (r_state == S_FETCH) && w_in_range && !redirect_valid &&
                   ((w_occupancy < 3'd2) || w_pop);

  // State register for the fetch/halt machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: redirect always resumes fetching; running off the end of memory halts.
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = S_FETCH;
    end else if ((r_state == S_FETCH) && !w_in_range) begin
      w_state_next = S_HALT;
    end
  end

  // Program counter and the single outstanding memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= 32'h0;
      r_inflight <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= {redirect_pc[31:2], 2'b00};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + 32'd4;
      end
    end
  end

  // Two-entry instruction buffer; a redirect flushes it after any same-edge pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_instr0 <= 32'h0;
      r_instr1 <= 32'h0;
      r_pcq0   <= 32'h0;
      r_pcq1   <= 32'h0;
    end else if (redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_count == 2'd1) begin
            r_instr0 <= imem_instr;
            r_pcq0   <= r_req_pc;
          end else begin
            r_instr0 <= r_instr1;
            r_pcq0   <= r_pcq1;
            r_instr1 <= imem_instr;
            r_pcq1   <= r_req_pc;
          end
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_instr0 <= imem_instr;
            r_pcq0   <= r_req_pc;
          end else begin
            r_instr1 <= imem_instr;
            r_pcq1   <= r_req_pc;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_instr0 <= r_instr1;
          r_pcq0   <= r_pcq1;
          r_count  <= r_count - 2'd1;
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam int unsigned MEM_DEPTH = 30;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        halted;

  logic [31:0] mem [0:63];

  int checks;
  int errors;

  fetch_unit #(.MEM_DEPTH(MEM_DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data for an address appears one edge later.
  always @(posedge clk) imem_instr <= mem[imem_addr[5:0]];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_linear;
    for (int i = 0; i < 64; i++) mem[i] = 32'(i);
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %0b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr got %h want 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc got %h want 0", if_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
    checks++; if (imem_addr !== {2'b00, RESET_PC[31:2]}) begin errors++; $display("FAIL reset_imem_addr got %h want %h", imem_addr, {2'b00, RESET_PC[31:2]}); end
  endtask

  task automatic test_stream;
    fill_linear;
    apply_reset;
    id_ready = 1'b1;
    tick;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid got %0b want 0", if_valid); end
    tick;
    for (int k = 0; k < 10; k++) begin
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", k, if_valid); end
      checks++; if (if_instr !== 32'(k)) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", k, if_instr, 32'(k)); end
      checks++; if (if_pc !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", k, if_pc, 32'(4 * k)); end
      tick;
    end
  endtask

  task automatic test_stall;
    fill_linear;
    apply_reset;
    tick;
    tick;
    for (int i = 0; i < 5; i++) begin
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0b want 1", i, if_valid); end
      checks++; if (if_instr !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("FAIL stall_hold[%0d] got instr %h pc %h want 0 0", i, if_instr, if_pc); end
      checks++; if (imem_addr !== 32'd2) begin errors++; $display("FAIL stall_no_issue[%0d] got imem_addr %h want 2", i, imem_addr); end
      tick;
    end
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (if_valid !== 1'b1 || if_instr !== 32'(k) || if_pc !== 32'(4 * k)) begin
        errors++; $display("FAIL stall_resume[%0d] got v %0b instr %h pc %h want 1 %h %h", k, if_valid, if_instr, if_pc, 32'(k), 32'(4 * k));
      end
      tick;
    end
  endtask

  task automatic test_redirect;
    fill_linear;
    apply_reset;
    tick;
    tick;
    tick;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0043;
    tick;
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redirect_flush got %0b want 0", if_valid); end
    checks++; if (imem_addr !== 32'd16) begin errors++; $display("FAIL redirect_addr got %h want 10", imem_addr); end
    tick;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redirect_gap got %0b want 0", if_valid); end
    tick;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'd16) begin
      errors++; $display("FAIL redirect_first got v %0b pc %h instr %h want 1 40 10", if_valid, if_pc, if_instr);
    end
    tick;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h44 || if_instr !== 32'd17) begin
      errors++; $display("FAIL redirect_second got v %0b pc %h instr %h want 1 44 11", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_halt;
    int n;
    logic [31:0] last_pc;
    logic [31:0] last_instr;
    n = 0;
    last_pc = 32'hffff_ffff;
    last_instr = 32'hffff_ffff;
    fill_linear;
    apply_reset;
    id_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (if_valid === 1'b1) begin
        n++;
        last_pc = if_pc;
        last_instr = if_instr;
      end
      if (halted === 1'b1) break;
      tick;
    end
    checks++; if (n !== 30) begin errors++; $display("FAIL halt_count got %0d want 30", n); end
    checks++; if (last_pc !== 32'h74 || last_instr !== 32'd29) begin errors++; $display("FAIL halt_last got pc %h instr %h want 74 1d", last_pc, last_instr); end
    checks++; if (halted !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL halt_state got halted %0b valid %0b want 1 0", halted, if_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    tick;
    redirect_valid = 1'b0;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_release got %0b want 0", halted); end
    tick;
    tick;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
      errors++; $display("FAIL halt_restart got v %0b pc %h instr %h want 1 0 0", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_reset_midop;
    fill_linear;
    apply_reset;
    tick;
    tick;
    tick;
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL midop_prefill got %0b want 1", if_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin
      errors++; $display("FAIL midop_async got v %0b instr %h pc %h want 0 0 0", if_valid, if_instr, if_pc);
    end
    checks++; if (imem_addr !== {2'b00, RESET_PC[31:2]}) begin errors++; $display("FAIL midop_pc got %h want %h", imem_addr, {2'b00, RESET_PC[31:2]}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    id_ready = 1'b1;
    tick;
    tick;
    checks++; if (if_valid !== 1'b1 || if_pc !== RESET_PC || if_instr !== mem[RESET_PC[7:2]]) begin
      errors++; $display("FAIL midop_restart got v %0b pc %h instr %h want 1 %h %h", if_valid, if_pc, if_instr, RESET_PC, mem[RESET_PC[7:2]]);
    end
  endtask

  // Reference: the accepted stream is the consecutive word sequence from the last
  // reset/redirect target, ending before MEM_DEPTH; stalls never alter the head.
  task automatic test_random;
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        stalled;
    logic        rd;
    int          gap;
    int          hcnt;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    apply_reset;
    exp_pc = RESET_PC;
    stalled = 1'b0;
    hold_instr = 32'h0;
    hold_pc = 32'h0;
    gap = 0;
    hcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (stalled) begin
        checks++; if (if_valid !== 1'b1 || if_instr !== hold_instr || if_pc !== hold_pc) begin
          errors++; $display("FAIL rand_hold c=%0d got v %0b instr %h pc %h want 1 %h %h", c, if_valid, if_instr, if_pc, hold_instr, hold_pc);
        end
      end
      if ((exp_pc >> 2) < MEM_DEPTH) begin
        hcnt = 0;
        if (if_valid !== 1'b1) gap++; else gap = 0;
        if (gap > 3) begin
          checks++; errors++; $display("FAIL rand_starve c=%0d no instruction for %0d cycles", c, gap);
        end
      end else begin
        gap = 0;
        hcnt++;
        if (hcnt > 3) begin
          checks++; if (halted !== 1'b1) begin errors++; $display("FAIL rand_halted c=%0d got %0b want 1", c, halted); end
        end
      end
      if (halted === 1'b1) begin
        checks++; if ((exp_pc >> 2) < MEM_DEPTH) begin errors++; $display("FAIL rand_early_halt c=%0d next expected pc %h", c, exp_pc); end
      end
      id_ready = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 49) == 0);
      tgt = $urandom_range(0, 35) * 4 + $urandom_range(0, 3);
      redirect_valid = rd;
      redirect_pc = tgt;
      if (if_valid === 1'b1 && id_ready) begin
        checks++; if ((exp_pc >> 2) >= MEM_DEPTH || if_pc !== exp_pc || if_instr !== mem[exp_pc[7:2]]) begin
          errors++; $display("FAIL rand_pop c=%0d got pc %h instr %h want pc %h instr %h", c, if_pc, if_instr, exp_pc, mem[exp_pc[7:2]]);
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (rd) begin
        exp_pc = {tgt[31:2], 2'b00};
        gap = 0;
        hcnt = 0;
      end
      stalled = (if_valid === 1'b1) && !id_ready && !rd;
      hold_instr = if_instr;
      hold_pc = if_pc;
      tick;
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b0;
    fill_linear;
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_halt;
    test_reset_midop;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
